// File: rtl/lc3_reg_file_cc.sv
// lc3_reg_file_cc
//   LC-3 architectural state: eight WIDTH-bit general-purpose registers,
//   the one-hot NZP condition codes and the registered branch-enable flag.
//
// Ports
//   Clk      in   system clock, all state updates on the rising edge
//   Reset    in   asynchronous active-low reset
//   IR       in   instruction register (register addresses, BEN condition bits)
//   Bus      in   shared datapath bus: writeback data and CC source
//   DRMUX    in   destination select: 0 = IR[11:9], 1 = R7
//   SR1MUX   in   SR1 select: 0 = IR[11:9], 1 = IR[8:6]
//   LD_REG   in   write Bus into the destination register
//   LD_CC    in   load NZP from Bus
//   LD_BEN   in   load BEN from IR[11:9] and the current NZP
//   SR1_OUT  out  SR1-selected register (ALU A)
//   SR2_OUT  out  register IR[2:0] (SR2 mux / ALU B)
//   N, Z, P  out  condition codes
//   BEN      out  branch enable
module lc3_reg_file_cc #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      IR,
    input  logic [WIDTH-1:0] Bus,
    input  logic             DRMUX,
    input  logic             SR1MUX,
    input  logic             LD_REG,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             BEN
);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_d;
    logic             ben_q;
    logic             ben_d;

    logic [2:0]       dr_addr;
    logic [2:0]       sr1_addr;
    logic [2:0]       sr2_addr;
    logic             bus_neg;
    logic             bus_zero;

    // Opcode and IR[5:3] are not used by this stage.
    logic             unused_ir;
    assign unused_ir = ^{IR[15:12], IR[5:3]};

    assign dr_addr  = DRMUX  ? 3'b111    : IR[11:9];
    assign sr1_addr = SR1MUX ? IR[8:6]   : IR[11:9];
    assign sr2_addr = IR[2:0];

    // No write bypass: reads always see the pre-edge register contents.
    assign SR1_OUT = regs_q[sr1_addr];
    assign SR2_OUT = regs_q[sr2_addr];

    assign bus_neg  = Bus[WIDTH-1];
    assign bus_zero = (Bus == '0);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        nzp_d = nzp_q;
        ben_d = ben_q;

        if (LD_REG) begin
            regs_d[dr_addr] = Bus;
        end

        if (LD_CC) begin
            nzp_d = {bus_neg, bus_zero, !bus_neg && !bus_zero};
        end

        // Uses nzp_q, so a CC load on the same edge does not affect BEN.
        if (LD_BEN) begin
            ben_d = |(IR[11:9] & nzp_q);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            nzp_q <= nzp_d;
            ben_q <= ben_d;
        end
    end

    assign N   = nzp_q[2];
    assign Z   = nzp_q[1];
    assign P   = nzp_q[0];
    assign BEN = ben_q;

endmodule

// File: tb/tb_lc3_reg_file_cc.sv
module tb_lc3_reg_file_cc;

    localparam int WIDTH = 16;

    logic             Clk;
    logic             Reset;
    logic [15:0]      IR;
    logic [WIDTH-1:0] Bus;
    logic             DRMUX;
    logic             SR1MUX;
    logic             LD_REG;
    logic             LD_CC;
    logic             LD_BEN;
    logic [WIDTH-1:0] SR1_OUT;
    logic [WIDTH-1:0] SR2_OUT;
    logic             N;
    logic             Z;
    logic             P;
    logic             BEN;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural state as plain variables.
    logic [15:0] mreg [8];
    bit          mn, mz, mp, mben;

    lc3_reg_file_cc #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .IR      (IR),
        .Bus     (Bus),
        .DRMUX   (DRMUX),
        .SR1MUX  (SR1MUX),
        .LD_REG  (LD_REG),
        .LD_CC   (LD_CC),
        .LD_BEN  (LD_BEN),
        .SR1_OUT (SR1_OUT),
        .SR2_OUT (SR2_OUT),
        .N       (N),
        .Z       (Z),
        .P       (P),
        .BEN     (BEN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
        mn = 0; mz = 1; mp = 0; mben = 0;
    endtask

    // One clock edge with the given controls; model updated alongside.
    task automatic cycle(input logic [15:0] ir, input logic [15:0] bus,
                         input logic drm, input logic s1m,
                         input logic lr, input logic lc, input logic lb);
        bit ben_new;
        IR = ir; Bus = bus; DRMUX = drm; SR1MUX = s1m;
        LD_REG = lr; LD_CC = lc; LD_BEN = lb;
        @(posedge Clk);
        ben_new = (ir[11] && mn) || (ir[10] && mz) || (ir[9] && mp);
        if (lr) mreg[drm ? 3'd7 : ir[11:9]] = bus;
        if (lc) begin
            mn = $signed(bus) < 0;
            mz = (bus == 16'h0000);
            mp = $signed(bus) > 0;
        end
        if (lb) mben = ben_new;
        #1;
        LD_REG = 0; LD_CC = 0; LD_BEN = 0;
    endtask

    task automatic test_reset();
        Reset = 0; IR = 0; Bus = 0; DRMUX = 0; SR1MUX = 0;
        LD_REG = 0; LD_CC = 0; LD_BEN = 0;
        model_reset();
        #2;
        for (int i = 0; i < 8; i++) begin
            IR = {7'd0, 3'(i), 3'd0, 3'(i)};
            SR1MUX = 1;
            #1;
            checks++;
            if (SR1_OUT !== 16'h0000 || SR2_OUT !== 16'h0000) begin
                failures++;
                $display("FAIL reset_regs r%0d: sr1=%h sr2=%h expected 0000", i, SR1_OUT, SR2_OUT);
            end
        end
        checks++;
        if ({N, Z, P, BEN} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_flags: nzp_ben=%b expected 0100", {N, Z, P, BEN});
        end
        @(negedge Clk);
        Reset = 1;
        @(posedge Clk); #1;

        // Write R3 = 1234, load P, and load BEN from the old Z (IR[11:9]=011).
        cycle(16'h0600, 16'h1234, 0, 0, 1, 1, 1);
        IR = 16'h0603; SR1MUX = 0; #1;
        checks++;
        if (SR1_OUT !== 16'h1234 || SR2_OUT !== 16'h1234 || {N, Z, P, BEN} !== 4'b0011) begin
            failures++;
            $display("FAIL pre_reset_state: sr1=%h sr2=%h nzp_ben=%b expected 1234 1234 0011",
                     SR1_OUT, SR2_OUT, {N, Z, P, BEN});
        end
        #2;
        Reset = 0;
        model_reset();
        #1;
        checks++;
        if (SR1_OUT !== 16'h0000 || SR2_OUT !== 16'h0000 || {N, Z, P, BEN} !== 4'b0100) begin
            failures++;
            $display("FAIL async_reset: sr1=%h sr2=%h nzp_ben=%b expected 0000 0000 0100",
                     SR1_OUT, SR2_OUT, {N, Z, P, BEN});
        end
        @(negedge Clk);
        Reset = 1;
        @(posedge Clk); #1;
    endtask

    task automatic test_write_read_all();
        for (int i = 0; i < 8; i++) begin
            cycle({4'd0, 3'(i), 9'd0}, 16'hA000 + 16'(i), 0, 0, 1, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            IR = {7'd0, 3'(i), 3'd0, 3'(i)};
            SR1MUX = 1;
            #1;
            checks++;
            if (SR1_OUT !== mreg[i] || SR2_OUT !== mreg[i] || mreg[i] !== 16'hA000 + 16'(i)) begin
                failures++;
                $display("FAIL write_read r%0d: sr1=%h sr2=%h expected %h", i, SR1_OUT, SR2_OUT,
                         16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_r7_rbw();
        logic [15:0] old_r7;
        old_r7 = mreg[7];
        IR = 16'h0607; Bus = 16'h0F0F; DRMUX = 1; SR1MUX = 0; LD_REG = 1;
        #1;
        checks++;
        if (SR2_OUT !== old_r7) begin
            failures++;
            $display("FAIL r7_before_edge: sr2=%h expected %h", SR2_OUT, old_r7);
        end
        cycle(16'h0607, 16'h0F0F, 1, 0, 1, 0, 0);
        checks++;
        if (SR2_OUT !== 16'h0F0F || SR1_OUT !== mreg[3]) begin
            failures++;
            $display("FAIL r7_after_edge: sr2=%h sr1(r3)=%h expected 0f0f %h", SR2_OUT, SR1_OUT, mreg[3]);
        end
        DRMUX = 0;
    endtask

    task automatic test_cc();
        logic [15:0] vals [3];
        logic [2:0]  exp  [3];
        vals[0] = 16'h8000; exp[0] = 3'b100;
        vals[1] = 16'h0000; exp[1] = 3'b010;
        vals[2] = 16'h7FFF; exp[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            cycle(16'h0000, vals[i], 0, 0, 0, 1, 0);
            checks++;
            if ({N, Z, P} !== exp[i] || {N, Z, P} !== {mn, mz, mp}) begin
                failures++;
                $display("FAIL cc_load bus=%h: nzp=%b expected %b", vals[i], {N, Z, P}, exp[i]);
            end
        end
        cycle(16'h0000, 16'h8000, 0, 0, 0, 0, 0);
        checks++;
        if ({N, Z, P} !== 3'b001) begin
            failures++;
            $display("FAIL cc_hold: nzp=%b expected 001", {N, Z, P});
        end
    endtask

    task automatic test_ben();
        // NZP is 001 from the preceding CC test.
        cycle(16'h0200, 16'h0000, 0, 0, 0, 0, 1);
        checks++;
        if (BEN !== 1'b1) begin
            failures++;
            $display("FAIL ben_p_taken: ben=%b expected 1", BEN);
        end
        cycle(16'h0C00, 16'h0000, 0, 0, 0, 0, 1);
        checks++;
        if (BEN !== 1'b0) begin
            failures++;
            $display("FAIL ben_nz_not_taken: ben=%b expected 0", BEN);
        end
        cycle(16'h0200, 16'hFFFF, 0, 0, 0, 1, 1);
        checks++;
        if (BEN !== 1'b1 || {N, Z, P} !== 3'b100) begin
            failures++;
            $display("FAIL ben_old_cc: ben=%b nzp=%b expected 1 100", BEN, {N, Z, P});
        end
    endtask

    task automatic test_combined();
        // NZP = 100 beforehand; IR[11:9] = 010 tests Z, so BEN must come out 0.
        cycle(16'h0400, 16'h0000, 0, 0, 1, 1, 1);
        IR = 16'h0402; SR1MUX = 0; #1;
        checks++;
        if (SR1_OUT !== 16'h0000 || SR2_OUT !== 16'h0000 || {N, Z, P} !== 3'b010 || BEN !== 1'b0) begin
            failures++;
            $display("FAIL combined: r2=%h/%h nzp=%b ben=%b expected 0000 010 0",
                     SR1_OUT, SR2_OUT, {N, Z, P}, BEN);
        end
        for (int i = 0; i < 8; i++) begin
            IR = {7'd0, 3'(i), 3'd0, 3'(i)}; SR1MUX = 1; #1;
            checks++;
            if (SR1_OUT !== mreg[i]) begin
                failures++;
                $display("FAIL combined_others r%0d: got %h expected %h", i, SR1_OUT, mreg[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ir, bus;
        logic [2:0]  a1;
        int          sel;
        for (int n = 0; n < 300; n++) begin
            ir  = 16'($urandom);
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       bus = 16'h0000;
                1:       bus = 16'h8000;
                default: bus = 16'($urandom);
            endcase
            cycle(ir, bus, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            IR = 16'($urandom); SR1MUX = 1'($urandom); #1;
            a1 = SR1MUX ? IR[8:6] : IR[11:9];
            checks++;
            if (SR1_OUT !== mreg[a1] || SR2_OUT !== mreg[IR[2:0]]) begin
                failures++;
                $display("FAIL random_read %0d: sr1=%h sr2=%h expected %h %h", n, SR1_OUT, SR2_OUT,
                         mreg[a1], mreg[IR[2:0]]);
            end
            checks++;
            if ({N, Z, P} !== {mn, mz, mp} || BEN !== mben || $countones({N, Z, P}) != 1) begin
                failures++;
                $display("FAIL random_flags %0d: nzp=%b ben=%b expected %b %b", n, {N, Z, P}, BEN,
                         {mn, mz, mp}, mben);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read_all();
        test_r7_rbw();
        test_cc();
        test_ben();
        test_combined();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
